// File: rtl/grid_pkg.sv
// Shared constants and types for the grid write path: board geometry, the empty
// color code, the arbiter state and the grant-source encoding.
package grid_pkg;

  localparam int GRID_COLS       = 10;
  localparam int GRID_ROWS       = 20;
  localparam int NUM_SQUARES_DEF = GRID_COLS * GRID_ROWS;
  localparam int ADDR_W_DEF      = 9;
  localparam int COLOR_W_DEF     = 4;
  localparam int COLOR_EMPTY     = 0;

  typedef enum logic {
    ARB,
    CLEAR
  } arb_state_t;

  typedef enum logic {
    PIECE,
    SHIFT
  } grant_src_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. Input a maps to PIECE and input b to SHIFT in last_grant.
// force_off suppresses both grants and leaves the fairness history untouched.
module rr_arbiter2
  import grid_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic req_a,
  input  logic req_b,
  input  logic force_off,
  output logic grant_a,
  output logic grant_b
);

  grant_src_t last_grant;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the if/else can leave a value held over and infer a latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!force_off) begin
      if (req_a && (!req_b || last_grant == SHIFT)) grant_a = 1'b1;
      else if (req_b)                               grant_b = 1'b1;
    end
  end

  // A grant is only ever given to a valid requester, so every grant is a transfer.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // values from before the edge, independent of the order of the statements.
  always_ff @(posedge clk_in) begin
    if (rst_in)       last_grant <= SHIFT;
    else if (grant_a) last_grant <= PIECE;
    else if (grant_b) last_grant <= SHIFT;
  end

endmodule

// File: rtl/grid_write_arbiter.sv
// Shares the grid RAM write port between the piece engine, the shift engine and a
// board-clear sweep that has absolute priority. Optional macro GRID_WRITE_GUARD_EN
// drops out-of-range external writes and raises a sticky addr_error.
module grid_write_arbiter
  import grid_pkg::*;
#(
  parameter int NUM_SQUARES = NUM_SQUARES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int COLOR_W     = COLOR_W_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               piece_valid,
  input  logic [ADDR_W-1:0]  piece_addr,
  input  logic [COLOR_W-1:0] piece_color,
  output logic               piece_ready,
  input  logic               shift_valid,
  input  logic [ADDR_W-1:0]  shift_addr,
  input  logic [COLOR_W-1:0] shift_color,
  output logic               shift_ready,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
`ifdef GRID_WRITE_GUARD_EN
  output logic               addr_error,
`endif
  output logic               write_enable,
  output logic [ADDR_W-1:0]  square_write_addr,
  output logic [COLOR_W-1:0] write_color
);

  if (NUM_SQUARES > (1 << ADDR_W)) begin : g_addr_w_check
    $error("grid_write_arbiter: NUM_SQUARES does not fit in ADDR_W bits");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SQUARES - 1);

  arb_state_t         state, state_next;
  logic [ADDR_W-1:0]  sweep_cnt;
  logic               sweep_last;
  logic               force_off;
  logic               piece_grant, shift_grant;
  logic               xfer;
  logic               addr_ok;
  logic [ADDR_W-1:0]  sel_addr;
  logic [COLOR_W-1:0] sel_color;

  assign sweep_last = (sweep_cnt == LAST_ADDR);

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ARB;
    else        state <= state_next;
  end

  // Next-state logic; clear_start inside a sweep is deliberately not queued.
  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (clear_start) state_next = CLEAR;
      CLEAR:   if (sweep_last)  state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Output logic: the requesters are shut out during reset, the sweep, and the
  // cycle clear_start is seen, so the sweep never collides with a transfer.
  always_comb begin
    force_off  = rst_in || (state == CLEAR) || clear_start;
    clear_busy = (state == CLEAR);
  end

  rr_arbiter2 u_rr (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_a     (piece_valid),
    .req_b     (shift_valid),
    .force_off (force_off),
    .grant_a   (piece_grant),
    .grant_b   (shift_grant)
  );

  assign piece_ready = piece_grant;
  assign shift_ready = shift_grant;
  assign xfer        = piece_grant | shift_grant;
  assign sel_addr    = piece_grant ? piece_addr  : shift_addr;
  assign sel_color   = piece_grant ? piece_color : shift_color;

`ifdef GRID_WRITE_GUARD_EN
  assign addr_ok = (int'(sel_addr) < NUM_SQUARES);

  always_ff @(posedge clk_in) begin
    if (rst_in)              addr_error <= 1'b0;
    else if (xfer && !addr_ok) addr_error <= 1'b1;
  end
`else
  assign addr_ok = 1'b1;
`endif

  // The counter parks at zero outside a sweep, so every sweep starts from square 0.
  always_ff @(posedge clk_in) begin
    if (rst_in || state == ARB) sweep_cnt <= '0;
    else                        sweep_cnt <= sweep_cnt + 1'b1;
  end

  // Registered write port: one cycle behind the transfer or sweep step it reflects.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      write_enable      <= 1'b0;
      square_write_addr <= '0;
      write_color       <= '0;
      clear_done        <= 1'b0;
    end else begin
      clear_done <= (state == CLEAR) && sweep_last;
      if (state == CLEAR) begin
        write_enable      <= 1'b1;
        square_write_addr <= sweep_cnt;
        write_color       <= COLOR_W'(COLOR_EMPTY);
      end else if (xfer) begin
        write_enable      <= addr_ok;
        square_write_addr <= sel_addr;
        write_color       <= sel_color;
      end else begin
        write_enable      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grid_write_arbiter.sv
// Directed bench for grid_write_arbiter: single grants, round-robin alternation,
// full sweeps, sweep lockout, reset mid-sweep and the optional address guard.
module tb_grid_write_arbiter;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       piece_valid, shift_valid, clear_start;
  logic [8:0] piece_addr, shift_addr;
  logic [3:0] piece_color, shift_color;
  logic       piece_ready, shift_ready, clear_busy, clear_done;
  logic       write_enable;
  logic [8:0] square_write_addr;
  logic [3:0] write_color;
`ifdef GRID_WRITE_GUARD_EN
  logic       addr_error;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  grid_write_arbiter dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .piece_valid       (piece_valid),
    .piece_addr        (piece_addr),
    .piece_color       (piece_color),
    .piece_ready       (piece_ready),
    .shift_valid       (shift_valid),
    .shift_addr        (shift_addr),
    .shift_color       (shift_color),
    .shift_ready       (shift_ready),
    .clear_start       (clear_start),
    .clear_busy        (clear_busy),
    .clear_done        (clear_done),
`ifdef GRID_WRITE_GUARD_EN
    .addr_error        (addr_error),
`endif
    .write_enable      (write_enable),
    .square_write_addr (square_write_addr),
    .write_color       (write_color)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic we, input int addr, input int color);
    check({tag, ".we"}, 32'(write_enable), 32'(we));
    if (we) begin
      check({tag, ".addr"},  32'(square_write_addr), 32'(addr));
      check({tag, ".color"}, 32'(write_color),       32'(color));
    end
  endtask

  initial begin
    rst_in      = 1'b1;
    piece_valid = 1'b1;
    piece_addr  = 9'd1;
    piece_color = 4'd1;
    shift_valid = 1'b0;
    shift_addr  = '0;
    shift_color = '0;
    clear_start = 1'b0;
    tick();
    tick();

    // Reset values, with a requester already valid
    check("rst.piece_ready", 32'(piece_ready), 0);
    check("rst.shift_ready", 32'(shift_ready), 0);
    check("rst.we",          32'(write_enable), 0);
    check("rst.addr",        32'(square_write_addr), 0);
    check("rst.color",       32'(write_color), 0);
    check("rst.busy",        32'(clear_busy), 0);
    check("rst.done",        32'(clear_done), 0);
`ifdef GRID_WRITE_GUARD_EN
    check("rst.addr_error",  32'(addr_error), 0);
`endif

    // Single piece write: ready same cycle, write one cycle later
    rst_in = 1'b0; piece_addr = 9'd5; piece_color = 4'd3;
    #1;
    check("p1.piece_ready", 32'(piece_ready), 1);
    check("p1.shift_ready", 32'(shift_ready), 0);
    tick();
    piece_valid = 1'b0;
    check_write("p1.write", 1'b1, 5, 3);

    // Idle cycle produces no write
    tick();
    check_write("idle.write", 1'b0, 0, 0);

    // Single shift write; this leaves last_grant at SHIFT again
    shift_valid = 1'b1; shift_addr = 9'd7; shift_color = 4'd2;
    #1;
    check("s1.shift_ready", 32'(shift_ready), 1);
    check("s1.piece_ready", 32'(piece_ready), 0);
    tick();
    shift_valid = 1'b0;
    check_write("s1.write", 1'b1, 7, 2);

    // Both valid for 4 cycles: PIECE, SHIFT, PIECE, SHIFT
    piece_valid = 1'b1; piece_addr = 9'd10; piece_color = 4'd1;
    shift_valid = 1'b1; shift_addr = 9'd20; shift_color = 4'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d.piece_ready", i), 32'(piece_ready), 32'(i % 2 == 0));
      check($sformatf("rr%0d.shift_ready", i), 32'(shift_ready), 32'(i % 2 == 1));
      tick();
      check_write($sformatf("rr%0d.write", i), 1'b1,
                  (i % 2 == 0) ? 10 : 20, (i % 2 == 0) ? 1 : 2);
    end
    piece_valid = 1'b0; shift_valid = 1'b0;
    tick();
    check_write("rr.after", 1'b0, 0, 0);

    // Full sweep from idle
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("sw1.busy_start", 32'(clear_busy), 1);
    check_write("sw1.first", 1'b0, 0, 0);
    for (int k = 0; k < 200; k++) begin
      tick();
      check_write($sformatf("sw1.w%0d", k), 1'b1, k, 0);
      check($sformatf("sw1.busy%0d", k), 32'(clear_busy), 32'(k < 199));
      check($sformatf("sw1.done%0d", k), 32'(clear_done), 32'(k == 199));
    end
    tick();
    check("sw1.done_after", 32'(clear_done), 0);
    check_write("sw1.after", 1'b0, 0, 0);

    // Sweep with piece pending and clear_start re-pulsed at counter 50
    piece_valid = 1'b1; piece_addr = 9'd33; piece_color = 4'd5;
    shift_valid = 1'b1; shift_addr = 9'd44; shift_color = 4'd6;
    clear_start = 1'b1;
    #1;
    check("sw2.start_piece_ready", 32'(piece_ready), 0);
    check("sw2.start_shift_ready", 32'(shift_ready), 0);
    tick();
    clear_start = 1'b0;
    shift_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      clear_start = (c == 50);
      #1;
      check($sformatf("sw2.piece_ready%0d", c), 32'(piece_ready), 0);
      tick();
      clear_start = 1'b0;
      check_write($sformatf("sw2.w%0d", c), 1'b1, c, 0);
    end
    check("sw2.done", 32'(clear_done), 1);
    check("sw2.busy_end", 32'(clear_busy), 0);
    #1;
    check("sw2.piece_ready_resume", 32'(piece_ready), 1);
    tick();
    piece_valid = 1'b0;
    check_write("sw2.piece_write", 1'b1, 33, 5);
    check("sw2.done_after", 32'(clear_done), 0);

    // Reset at sweep counter 100
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    check_write("rs.w99", 1'b1, 99, 0);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("rs.we",    32'(write_enable), 0);
    check("rs.addr",  32'(square_write_addr), 0);
    check("rs.color", 32'(write_color), 0);
    check("rs.busy",  32'(clear_busy), 0);
    check("rs.done",  32'(clear_done), 0);
    tick();
    check("rs.done_late", 32'(clear_done), 0);
    check_write("rs.idle", 1'b0, 0, 0);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("rs.restart_busy", 32'(clear_busy), 1);
    tick();
    check_write("rs.restart_w0", 1'b1, 0, 0);
    tick();
    check_write("rs.restart_w1", 1'b1, 1, 0);

    // Reset coinciding with clear_start stays in ARB
    rst_in = 1'b1; clear_start = 1'b1;
    tick();
    rst_in = 1'b0; clear_start = 1'b0;
    check("rc.busy", 32'(clear_busy), 0);
    tick();
    check("rc.busy2", 32'(clear_busy), 0);
    check_write("rc.idle", 1'b0, 0, 0);

`ifdef GRID_WRITE_GUARD_EN
    // Out-of-range piece write is consumed but not written
    piece_valid = 1'b1; piece_addr = 9'd200; piece_color = 4'd7;
    #1;
    check("g.piece_ready", 32'(piece_ready), 1);
    tick();
    piece_valid = 1'b0;
    check_write("g.write", 1'b0, 0, 0);
    check("g.addr_error", 32'(addr_error), 1);
    shift_valid = 1'b1; shift_addr = 9'd199; shift_color = 4'd4;
    tick();
    shift_valid = 1'b0;
    check_write("g.valid_write", 1'b1, 199, 4);
    check("g.addr_error_held", 32'(addr_error), 1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("g.addr_error_rst", 32'(addr_error), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_write_arbiter.md
Name: grid_write_arbiter

Overview:
- Shares the single grid square-RAM write port (write_enable, square_write_addr, write_color) among three sources:
  - the active-piece draw engine;
  - the line-clear shift engine;
  - an internal board-clear sweep.
- Sits between the game logic and the display block's grid write inputs.
- Guarantees at most one write per cycle.
- Round-robin fairness between the two external requesters; the clear sweep has absolute priority.

Parameters:
- NUM_SQUARES, 200, number of grid cells (10 columns x 20 rows); valid addresses are 0..NUM_SQUARES-1.
- ADDR_W, 9, width of square addresses.
- COLOR_W, 4, width of the color code; 0 means empty cell.

Ports:
- clk_in input 1: system/pixel clock.
- rst_in input 1: synchronous, active-high reset.
- piece_valid input 1: piece engine has a write pending.
- piece_addr input ADDR_W: piece write address.
- piece_color input COLOR_W: piece write color.
- piece_ready output 1: piece write accepted this cycle.
- shift_valid input 1: shift engine has a write pending.
- shift_addr input ADDR_W: shift write address.
- shift_color input COLOR_W: shift write color.
- shift_ready output 1: shift write accepted this cycle.
- clear_start input 1: single-cycle pulse requesting a full-board clear.
- clear_busy output 1: sweep in progress.
- clear_done output 1: single-cycle pulse at sweep completion.
- write_enable output 1: grid RAM write strobe.
- square_write_addr output ADDR_W: grid RAM write address.
- write_color output COLOR_W: grid RAM write data.

Behaviour:
- Reset values:
  - write_enable=0, square_write_addr=0, write_color=0;
  - piece_ready=0, shift_ready=0;
  - clear_busy=0, clear_done=0;
  - state=ARB, last_grant=SHIFT, so the first contested grant goes to PIECE.
- States: ARB, CLEAR.
- ARB:
  - piece_ready/shift_ready are combinational from the valids and last_grant.
  - Only one requester valid: it is granted.
  - Both valid: the requester not in last_grant wins.
  - A transfer occurs when valid && ready in the same cycle.
  - last_grant updates on every transfer.
  - A requester must hold addr/color stable while valid is high and ready is low.
- Write port outputs are registered with 1-cycle latency: a transfer in cycle N drives write_enable=1 with that addr/color in cycle N+1.
  - Back-to-back transfers give one write per cycle.
  - write_enable=0 in any cycle following no transfer.
- clear_start in ARB:
  - Both readys are forced low in that same cycle, so no transfer occurs.
  - Next cycle: state=CLEAR, clear_busy=1, sweep counter=0.
- CLEAR:
  - Both readys are low.
  - Each cycle a write of color 0 is issued at the counter value, counter increments; the outputs are registered, so the first write appears in the first CLEAR cycle+1.
  - After the write to NUM_SQUARES-1 has been issued:
    - clear_done=1 for exactly one cycle, in the cycle after that write;
    - clear_busy=0 in that same cycle;
    - state returns to ARB.
  - A sweep takes NUM_SQUARES write cycles.
  - clear_start during CLEAR is ignored; it is not queued.
- Pending requester valids during CLEAR stay pending and are served after return to ARB.
  - Arbitration resumes with the last_grant held from before the sweep.
- Address width: sweep counter is ADDR_W bits. NUM_SQUARES must be <= 2^ADDR_W; this is checked with an elaboration-time assertion.
- rst_in mid-sweep: immediate return to reset values.
  - No clear_done is issued.
  - The partial clear is left as is.
- rst_in is synchronous; a rst_in coinciding with clear_start leaves the block in ARB.

Optional Feature:
- Macro: GRID_WRITE_GUARD_EN.
- Defined:
  - An accepted external write with addr >= NUM_SQUARES is consumed (ready still asserted) but produces no write_enable.
  - A sticky output addr_error (1 bit, reset 0) sets the cycle after such a transfer and clears only on rst_in.
- Undefined:
  - No addr_error port.
  - All accepted writes pass through unchecked.

Decomposition:
- Shared package grid_pkg:
  - NUM_SQUARES default, GRID_COLS=10, GRID_ROWS=20;
  - COLOR_EMPTY=0;
  - typedef enum for arbiter state {ARB, CLEAR};
  - typedef enum for grant source {PIECE, SHIFT}.
- One sub-module is natural: rr_arbiter2, a 2-input round-robin grant with a last_grant register and a force_off input, reusable for the flash/speck write paths.

Test Plan:
- After reset, piece_valid=1 addr=5 color=3, shift_valid=0 -> piece_ready=1 same cycle; next cycle write_enable=1, square_write_addr=5, write_color=3.
- Both valid continuously for 4 cycles (piece addr 10, shift addr 20) -> grants alternate PIECE, SHIFT, PIECE, SHIFT; write addresses 10, 20, 10, 20 on consecutive cycles.
- clear_start pulse while idle -> clear_busy high next cycle; writes addr 0..199 with color 0 on 200 consecutive cycles; clear_done single pulse the cycle after the addr-199 write; clear_busy low in that cycle.
- piece_valid=1 held during a sweep, with a clear_start re-pulse at addr 50 -> piece_ready stays 0 and the sweep is not restarted; piece is granted the first ARB cycle after clear_done.
- rst_in asserted at sweep addr 100 -> next cycle all outputs at reset values, no clear_done; a new clear_start restarts from addr 0.
- With GRID_WRITE_GUARD_EN: piece addr 200 -> ready=1, no write_enable, addr_error=1 next cycle and held until rst_in.
